// File: rtl/lift_call_scheduler.sv
// Collective (SCAN) scheduler for a single lift car: latches hall/cab calls into a
// pending bitmap and sequences the car through IDLE / MOVE / DOOR.
module lift_call_scheduler #(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned FLOOR_W     = 3,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOOR_W-1:0]    hall_call,
  input  logic [FLOOR_W-1:0]    cab_call,
  output logic [FLOOR_W-1:0]    floor_o,
  output logic                  dir_o,
  output logic                  moving_o,
  output logic                  door_open_o,
  output logic                  busy_o,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int unsigned CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [FLOOR_W-1:0]    floor_nxt;
  logic                  dir_nxt;
  logic [NUM_FLOORS-1:0] pend_nxt, set_mask, clr_mask, here, arrive;
  logic                  above_any, below_any, ahead_any, behind_any, beyond_any;
  logic                  hall_here, cab_here;

  // One-hot bit for a floor number; zero for 0 or out-of-range values.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (32'(f) == i + 1);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] mask_above(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i + 1 > 32'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] mask_below(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (i + 1 < 32'(f));
    return m;
  endfunction

  always_comb begin
    here       = floor_bit(floor_o);
    above_any  = |(pending_o & mask_above(floor_o));
    below_any  = |(pending_o & mask_below(floor_o));
    ahead_any  = dir_o ? below_any : above_any;
    behind_any = dir_o ? above_any : below_any;
    // A call for the open-door floor extends the dwell instead of queueing a revisit.
    hall_here  = (state == DOOR) && (hall_call == floor_o);
    cab_here   = (state == DOOR) && (cab_call == floor_o);
    set_mask   = (hall_here ? '0 : floor_bit(hall_call)) | (cab_here ? '0 : floor_bit(cab_call));

    state_nxt  = state;
    floor_nxt  = floor_o;
    dir_nxt    = dir_o;
    cnt_nxt    = cnt;
    clr_mask   = '0;
    arrive     = '0;
    beyond_any = 1'b0;

    case (state)
      IDLE: begin
        if (|(pending_o & here)) begin
          state_nxt = DOOR;
          cnt_nxt   = DOOR_LOAD;
          clr_mask  = here;
        end else if (above_any || below_any) begin
          state_nxt = MOVE;
          cnt_nxt   = MOVE_LOAD;
          if (!ahead_any) dir_nxt = ~dir_o;
        end
      end
      MOVE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          floor_nxt  = dir_o ? floor_o - 1'b1 : floor_o + 1'b1;
          arrive     = floor_bit(floor_nxt);
          beyond_any = dir_o ? |(pending_o & mask_below(floor_nxt))
                             : |(pending_o & mask_above(floor_nxt));
          if (|(pending_o & arrive)) begin
            state_nxt = DOOR;
            cnt_nxt   = DOOR_LOAD;
            clr_mask  = arrive;
          end else if (beyond_any) begin
            cnt_nxt = MOVE_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DOOR: begin
        if (hall_here || cab_here) begin
          cnt_nxt = DOOR_LOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (ahead_any) begin
          state_nxt = MOVE;
          cnt_nxt   = MOVE_LOAD;
        end else if (behind_any) begin
          state_nxt = MOVE;
          cnt_nxt   = MOVE_LOAD;
          dir_nxt   = ~dir_o;
        end else if (|(pending_o & here)) begin
          cnt_nxt  = DOOR_LOAD;
          clr_mask = here;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // New calls win over the clear so a call landing on the arrival edge is kept.
    pend_nxt = (pending_o & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      floor_o     <= FLOOR_W'(1);
      dir_o       <= 1'b0;
      cnt         <= '0;
      pending_o   <= '0;
      moving_o    <= 1'b0;
      door_open_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      floor_o     <= floor_nxt;
      dir_o       <= dir_nxt;
      cnt         <= cnt_nxt;
      pending_o   <= pend_nxt;
      moving_o    <= (state_nxt == MOVE);
      door_open_o <= (state_nxt == DOOR);
      busy_o      <= (state_nxt != IDLE) || (|pend_nxt);
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Self-checking bench for lift_call_scheduler: directed scenarios plus random calls
// compared against a floor-array reference model.
module tb_lift_call_scheduler;

  localparam int NF = 8;
  localparam int FW = 4;
  localparam int MC = 4;
  localparam int DC = 6;

  logic          clk;
  logic          rst_n;
  logic [FW-1:0] hall_call, cab_call;
  logic [FW-1:0] floor_o;
  logic          dir_o, moving_o, door_open_o, busy_o;
  logic [NF-1:0] pending_o;

  int errors = 0;
  int checks = 0;

  lift_call_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hall_call  (hall_call),
    .cab_call   (cab_call),
    .floor_o    (floor_o),
    .dir_o      (dir_o),
    .moving_o   (moving_o),
    .door_open_o(door_open_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: requests per floor, signed direction, phase with cycles left.
  bit req[1:NF];
  int m_fl, m_dir, m_ph, m_left;   // m_ph: 0 idle, 1 travelling, 2 door open

  function automatic bit work(input int d);
    for (int f = m_fl + d; f >= 1 && f <= NF; f += d)
      if (req[f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NF-1:0] req_bits();
    logic [NF-1:0] b;
    b = '0;
    for (int f = 1; f <= NF; f++) b[f-1] = req[f];
    return b;
  endfunction

  task automatic model_reset();
    for (int f = 1; f <= NF; f++) req[f] = 1'b0;
    m_fl = 1; m_dir = 1; m_ph = 0; m_left = 0;
  endtask

  task automatic model_step(input int h, input int c);
    bit was_door;
    int fl0, clr;
    was_door = (m_ph == 2);
    fl0 = m_fl;
    clr = 0;
    case (m_ph)
      0: if (req[m_fl]) begin
           m_ph = 2; m_left = DC; clr = m_fl;
         end else if (work(1) || work(-1)) begin
           if (!work(m_dir)) m_dir = -m_dir;
           m_ph = 1; m_left = MC;
         end
      1: begin
           m_left--;
           if (m_left == 0) begin
             m_fl += m_dir;
             if (req[m_fl]) begin m_ph = 2; m_left = DC; clr = m_fl; end
             else m_left = MC;
           end
         end
      default: begin
           if (h == m_fl || c == m_fl) m_left = DC;
           else begin
             m_left--;
             if (m_left == 0) begin
               if (work(m_dir)) begin m_ph = 1; m_left = MC; end
               else if (work(-m_dir)) begin m_dir = -m_dir; m_ph = 1; m_left = MC; end
               else if (req[m_fl]) begin m_left = DC; clr = m_fl; end
               else m_ph = 0;
             end
           end
         end
    endcase
    if (clr != 0) req[clr] = 1'b0;
    if (h >= 1 && h <= NF && !(was_door && h == fl0)) req[h] = 1'b1;
    if (c >= 1 && c <= NF && !(was_door && c == fl0)) req[c] = 1'b1;
  endtask

  // Drive calls for one cycle, then sample 1 time unit after the edge.
  task automatic tick(input int h, input int c);
    hall_call = FW'(h);
    cab_call  = FW'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hall_call = '0; cab_call = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  int stop_fl[$];
  int stop_dir[$];
  int door_len[$];

  // Runs until the car is idle, logging each door stop and its dwell length.
  task automatic run_record(input int max_cycles, input int inj_at, input int inj_cab,
                            output bit timed_out);
    bit prev_door, injected;
    int len;
    stop_fl.delete(); stop_dir.delete(); door_len.delete();
    prev_door = door_open_o; injected = 1'b0; len = 0; timed_out = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      if (inj_at != 0 && !injected && moving_o && int'(floor_o) == inj_at) begin
        tick(0, inj_cab); injected = 1'b1;
      end else tick(0, 0);
      if (door_open_o && !prev_door) begin
        stop_fl.push_back(int'(floor_o)); stop_dir.push_back(int'(dir_o)); len = 0;
      end
      if (door_open_o) len++;
      else if (prev_door) door_len.push_back(len);
      prev_door = door_open_o;
      if (!busy_o) begin timed_out = 1'b0; break; end
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; hall_call = 4'd3; cab_call = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o} !== {4'd1, 4'b0000, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got floor=%0d dir=%0b mv=%0b door=%0b busy=%0b pend=%h, want floor=1 all others 0",
               floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o);
    end
    rst_n = 1'b1; hall_call = '0; cab_call = '0;
    model_reset();
  endtask

  task automatic test_single_call();
    int ef;
    bit em, ed, eb;
    do_reset();
    tick(3, 0);
    checks++;
    if (pending_o !== 8'b0000_0100 || moving_o !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: got pend=%h mv=%0b, want pend=04 mv=0", pending_o, moving_o);
    end
    for (int k = 2; k <= 17; k++) begin
      tick(0, 0);
      ef = (k < 6) ? 1 : (k < 10) ? 2 : 3;
      em = (k >= 2 && k <= 9);
      ed = (k >= 10 && k <= 15);
      eb = (k <= 15);
      checks++;
      if (int'(floor_o) != ef || moving_o !== em || door_open_o !== ed || busy_o !== eb) begin
        errors++;
        $display("FAIL single_timing N+%0d: got floor=%0d mv=%0b door=%0b busy=%0b, want floor=%0d mv=%0b door=%0b busy=%0b",
                 k, floor_o, moving_o, door_open_o, busy_o, ef, em, ed, eb);
      end
    end
  endtask

  task automatic test_cab_stop();
    bit to;
    do_reset();
    tick(7, 0);
    run_record(300, 2, 4, to);
    checks++;
    if (to || stop_fl.size() != 2 || q_at(stop_fl, 0) != 4 || q_at(stop_fl, 1) != 7) begin
      errors++;
      $display("FAIL cab_stop_order: timeout=%0b stops=%0d first=%0d second=%0d, want 2 stops 4 then 7",
               to, stop_fl.size(), q_at(stop_fl, 0), q_at(stop_fl, 1));
    end
    checks++;
    if (q_at(door_len, 0) != DC || q_at(door_len, 1) != DC || int'(floor_o) != 7) begin
      errors++;
      $display("FAIL cab_stop_dwell: got dwell=%0d,%0d floor=%0d, want dwell=%0d,%0d floor=7",
               q_at(door_len, 0), q_at(door_len, 1), floor_o, DC, DC);
    end
  endtask

  task automatic test_scan_reverse();
    bit to;
    do_reset();
    tick(5, 0);
    run_record(300, 0, 0, to);
    checks++;
    if (to || int'(floor_o) != 5 || dir_o !== 1'b0) begin
      errors++;
      $display("FAIL scan_setup: timeout=%0b floor=%0d dir=%0b, want floor=5 dir=0", to, floor_o, dir_o);
    end
    tick(2, 7);
    checks++;
    if (pending_o !== 8'b0100_0010) begin
      errors++;
      $display("FAIL scan_capture: got pend=%h, want 42", pending_o);
    end
    run_record(300, 0, 0, to);
    checks++;
    if (to || q_at(stop_fl, 0) != 7 || q_at(stop_fl, 1) != 2 || stop_fl.size() != 2 ||
        q_at(stop_dir, 0) != 0 || q_at(stop_dir, 1) != 1) begin
      errors++;
      $display("FAIL scan_order: stops=%0d (%0d dir%0d, %0d dir%0d), want 7 dir0 then 2 dir1",
               stop_fl.size(), q_at(stop_fl, 0), q_at(stop_dir, 0), q_at(stop_fl, 1), q_at(stop_dir, 1));
    end
    checks++;
    if (pending_o !== 8'h00 || busy_o !== 1'b0 || int'(floor_o) != 2) begin
      errors++;
      $display("FAIL scan_end: got pend=%h busy=%0b floor=%0d, want pend=00 busy=0 floor=2",
               pending_o, busy_o, floor_o);
    end
  endtask

  task automatic test_door_restart();
    int n, dcnt;
    bit pend_seen;
    do_reset();
    tick(0, 4);
    n = 0;
    while (!door_open_o && n < 100) begin tick(0, 0); n++; end
    checks++;
    if (!door_open_o || int'(floor_o) != 4) begin
      errors++;
      $display("FAIL door_reach: got door=%0b floor=%0d, want door=1 floor=4", door_open_o, floor_o);
    end
    dcnt = 0; pend_seen = 1'b0;
    while (door_open_o && dcnt < 50) begin
      dcnt++;
      if (pending_o[3]) pend_seen = 1'b1;
      tick(0, (dcnt == 3) ? 4 : 0);
    end
    checks++;
    if (dcnt != 3 + DC || pend_seen) begin
      errors++;
      $display("FAIL door_restart: got door cycles=%0d bit4_set=%0b, want %0d cycles bit4_set=0",
               dcnt, pend_seen, 3 + DC);
    end
  endtask

  task automatic test_ignore_and_dual();
    bit to;
    do_reset();
    tick(0, 0);
    tick(9, 0);
    tick(0, 15);
    checks++;
    if (pending_o !== 8'h00 || busy_o !== 1'b0 || moving_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_invalid: got pend=%h busy=%0b mv=%0b, want 00 0 0", pending_o, busy_o, moving_o);
    end
    tick(6, 2);
    checks++;
    if (pending_o !== 8'b0010_0010 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL dual_capture: got pend=%h busy=%0b, want pend=22 busy=1", pending_o, busy_o);
    end
    run_record(300, 0, 0, to);
    checks++;
    if (to || stop_fl.size() != 2 || q_at(stop_fl, 0) != 2 || q_at(stop_fl, 1) != 6) begin
      errors++;
      $display("FAIL dual_order: timeout=%0b stops=%0d first=%0d second=%0d, want 2 then 6",
               to, stop_fl.size(), q_at(stop_fl, 0), q_at(stop_fl, 1));
    end
  endtask

  task automatic test_reset_mid_move();
    int n;
    do_reset();
    tick(6, 0);
    n = 0;
    while (!(moving_o && int'(floor_o) == 3) && n < 100) begin tick(0, 0); n++; end
    tick(0, 8);
    tick(0, 0);
    checks++;
    if (!moving_o || int'(floor_o) != 3 || pending_o !== 8'b1010_0000) begin
      errors++;
      $display("FAIL midmove_setup: got mv=%0b floor=%0d pend=%h, want mv=1 floor=3 pend=a0",
               moving_o, floor_o, pending_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o} !== {4'd1, 4'b0000, 8'h00}) begin
      errors++;
      $display("FAIL midmove_async_reset: got floor=%0d dir=%0b mv=%0b door=%0b busy=%0b pend=%h, want floor=1 rest 0",
               floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o);
    end
    rst_n = 1'b1;
    model_reset();
    tick(0, 0);
    tick(0, 0);
    checks++;
    if (moving_o !== 1'b0 || busy_o !== 1'b0 || int'(floor_o) != 1) begin
      errors++;
      $display("FAIL midmove_after: got mv=%0b busy=%0b floor=%0d, want 0 0 1", moving_o, busy_o, floor_o);
    end
  endtask

  task automatic test_random();
    int h, c;
    logic [15:0] exp_v, got_v;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      h = 0; c = 0;
      if ($urandom_range(0, 9) == 0) h = int'($urandom_range(0, 10));
      if ($urandom_range(0, 9) == 0) c = int'($urandom_range(0, 10));
      if ($urandom_range(0, 15) == 0) c = int'(floor_o);
      tick(h, c);
      model_step(h, c);
      exp_v = {FW'(m_fl), (m_dir < 0), (m_ph == 1), (m_ph == 2),
               (m_ph != 0) || (req_bits() != '0), req_bits()};
      got_v = {floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d h=%0d c=%0d: got floor/dir/mv/door/busy/pend=%0d/%0b/%0b/%0b/%0b/%h, want %0d/%0b/%0b/%0b/%0b/%h",
                 cyc, h, c, got_v[15:12], got_v[11], got_v[10], got_v[9], got_v[8], got_v[7:0],
                 exp_v[15:12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; hall_call = '0; cab_call = '0;
    #3;
    test_reset();
    test_single_call();
    test_cab_stop();
    test_scan_reverse();
    test_door_restart();
    test_ignore_and_dual();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
